vga_mode_ctrl: RTL
==================

# vga_mode_ctrl

Sequencer that owns VGA mode changes. It accepts a resolution request and gates the timing generator off at a frame boundary. It then fetches the new timing/frequency set from the resolution memory, programs the pixel-clock generator, and waits for stable lock before re-enabling scan-out. It sits between the register/host side and the resolution memory, pixel-clock generator and timing generator.

## Interface
- RES_W, 1, width of resolution code (vga_resolution_e)
- LOCK_STABLE, 16, consecutive cycles clk_locked_i must be high before enable
- LOCK_TIMEOUT, 65535, max cycles in LOCK_WAIT before error; counter width $clog2(LOCK_TIMEOUT+1)

Ports:
- clk_i  in  1  system clock
- arstn_i  in  1  reset, asynchronous, active-low
- mode_i  in  RES_W  requested resolution, sampled with mode_req_i
- mode_req_i  in  1  single-cycle request; accepted only when busy_o=0
- busy_o  out  1  high in every state except IDLE, RUN, ERR
- done_o  out  1  one-cycle pulse on entry to RUN
- err_o  out  1  high while in ERR
- mem_res_o  out  RES_W  resolution code to memory, registered at accept
- mem_req_o  out  1  one-cycle lookup pulse
- mem_valid_i  in  1  toggle; every completed lookup inverts it
- freq_int_i, freq_frac_i  in  8 each  pixel-clock value from memory
- clk_cfg_int_o, clk_cfg_frac_o  out  8 each  pixel-clock setting, captured when the lookup completes
- clk_cfg_req_o  out  1  level request to clock generator
- clk_cfg_ack_i  in  1  clock generator accepted settings
- clk_locked_i  in  1  clock generator lock status (already synchronised)
- tg_frame_end_i  in  1  one-cycle pulse at last pixel of frame
- tg_en_o  out  1  timing generator enable

## Operation
- States: IDLE, DRAIN, LOOKUP, CLKCFG, LOCK_WAIT, RUN, ERR.
- IDLE: on mode_req_i, register mode_i into mem_res_o and go to LOOKUP.
- RUN: on mode_req_i, register mode_i and go to DRAIN. If clk_locked_i goes low: clear tg_en_o, go to LOCK_WAIT (relock path). done_o pulses again on return to RUN.
- DRAIN: keep tg_en_o=1 until tg_frame_end_i. On that pulse: tg_en_o=0 next cycle, go to LOOKUP.
- LOOKUP: mem_req_o=1 in the first cycle only. The block holds a copy of mem_valid_i's last value. When mem_valid_i differs from the copy: capture freq_int_i/freq_frac_i into clk_cfg_*_o, update the copy, go to CLKCFG.
- CLKCFG: clk_cfg_req_o=1 until clk_cfg_ack_i is sampled high. In that same cycle: drop the request, go to LOCK_WAIT, clear both counters.
- LOCK_WAIT:
  - Stable counter increments while clk_locked_i=1 and resets to 0 when it is 0.
  - Stable counter = LOCK_STABLE-1 with lock high: go to RUN, tg_en_o=1, done_o pulse.
  - Timeout counter increments every cycle. Reaching LOCK_TIMEOUT (stable condition not met) goes to ERR. Stable takes priority if both occur in the same cycle.
- ERR: tg_en_o=0, err_o=1. mode_req_i is accepted and goes to LOOKUP, clearing err_o.
- mode_req_i while busy_o=1 is ignored; no queuing.
- mode_req_i and a clk_locked_i drop in the same RUN cycle: the request wins, go to DRAIN. tg_frame_end_i still ends DRAIN.

## Timing
- Reset values: state IDLE; all outputs 0; mem_res_o=0; clk_cfg_*_o=0; mem_valid copy=0; counters 0.
- All outputs are registered, driven from state/flops.
- Accept (edge N) to mem_req_o high: cycle N+1.
- Toggle seen (edge M) to clk_cfg_req_o high and clk_cfg_*_o valid: cycle M+1.
- clk_cfg_*_o are stable while clk_cfg_req_o=1.
- Ack sampled (edge A): clk_cfg_req_o low at A+1.
- Minimum LOCK_WAIT dwell is LOCK_STABLE cycles with lock continuously high from entry.
- Asynchronous reset mid-sequence: immediately IDLE with all outputs 0. A pending clock-generator handshake is abandoned.

## Test plan
- Cold start: reset, then mode_req_i with mode_i=0. Memory toggles mem_valid_i 2 cycles after mem_req_o with freq 40/0. Ack after 3 cycles; lock held high. Required: clk_cfg_int_o=40, clk_cfg_frac_o=0; done_o and tg_en_o rise exactly LOCK_STABLE cycles after LOCK_WAIT entry.
- Mode change in RUN: request mid-frame. Required: tg_en_o stays 1 until tg_frame_end_i, falls the next cycle; mem_req_o pulses once; busy_o=1 throughout until RUN.
- Lock glitch: during LOCK_WAIT, lock high 10 cycles, low 1, then high. Required: RUN reached LOCK_STABLE cycles after the lock recovers, not before.
- Timeout: with LOCK_TIMEOUT=100, lock never asserts. Required: err_o=1 and tg_en_o=0 after 100 cycles in LOCK_WAIT. A new mode_req_i clears err_o and issues mem_req_o.
- Busy requests and relock: mode_req_i during LOOKUP is ignored (mem_res_o unchanged, no extra mem_req_o). A clk_locked_i drop in RUN clears tg_en_o next cycle, and a second done_o follows after re-lock.
- Reset mid-CLKCFG: assert arstn_i low while clk_cfg_req_o=1. Required: all outputs 0 immediately, state IDLE after release.

Source files
------------

// File: rtl/vga_mode_ctrl.sv
`timescale 1ns/1ps
// VGA mode-change sequencer: drains the timing generator at a frame boundary,
// fetches the new pixel-clock setting, programs the clock generator and waits for lock.
module vga_mode_ctrl #(
    parameter int unsigned RES_W        = 1,
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic [RES_W-1:0] mode_i,
    input  logic             mode_req_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [RES_W-1:0] mem_res_o,
    output logic             mem_req_o,
    input  logic             mem_valid_i,
    input  logic [7:0]       freq_int_i,
    input  logic [7:0]       freq_frac_i,
    output logic [7:0]       clk_cfg_int_o,
    output logic [7:0]       clk_cfg_frac_o,
    output logic             clk_cfg_req_o,
    input  logic             clk_cfg_ack_i,
    input  logic             clk_locked_i,
    input  logic             tg_frame_end_i,
    output logic             tg_en_o
);

    localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_LOOKUP, S_CLKCFG, S_LOCK_WAIT, S_RUN, S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic [RES_W-1:0]   mem_res_q, mem_res_d;
    logic [7:0]         cfg_int_q, cfg_int_d;
    logic [7:0]         cfg_frac_q, cfg_frac_d;
    logic               vld_q, vld_d;
    logic [STB_W-1:0]   stb_q, stb_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               mem_req_q, mem_req_d;
    logic               cfg_req_q, cfg_req_d;
    logic               tg_en_q, tg_en_d;

    // Next-state and next-output logic; outputs are decoded from the next state.
    always_comb begin
        state_d    = state_q;
        mem_res_d  = mem_res_q;
        cfg_int_d  = cfg_int_q;
        cfg_frac_d = cfg_frac_q;
        vld_d      = vld_q;
        stb_d      = '0;
        tmo_d      = '0;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (mode_req_i) begin
                    mem_res_d = mode_i;
                    state_d   = S_LOOKUP;
                end
            end
            S_RUN: begin
                if (mode_req_i) begin
                    mem_res_d = mode_i;
                    state_d   = S_DRAIN;
                end else if (!clk_locked_i) begin
                    state_d = S_LOCK_WAIT;
                end
            end
            S_DRAIN: begin
                if (tg_frame_end_i) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                // The memory signals completion by inverting mem_valid_i.
                if (mem_valid_i != vld_q) begin
                    cfg_int_d  = freq_int_i;
                    cfg_frac_d = freq_frac_i;
                    vld_d      = mem_valid_i;
                    state_d    = S_CLKCFG;
                end
            end
            S_CLKCFG: begin
                if (clk_cfg_ack_i) state_d = S_LOCK_WAIT;
            end
            S_LOCK_WAIT: begin
                stb_d = clk_locked_i ? stb_q + STB_W'(1) : '0;
                tmo_d = tmo_q + TMO_W'(1);
                if (clk_locked_i && (stb_q == STB_W'(LOCK_STABLE - 1))) begin
                    state_d = S_RUN;
                end else if (tmo_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d    = !((state_d == S_IDLE) || (state_d == S_RUN) || (state_d == S_ERR));
        done_d    = (state_d == S_RUN) && (state_q != S_RUN);
        err_d     = (state_d == S_ERR);
        mem_req_d = (state_d == S_LOOKUP) && (state_q != S_LOOKUP);
        cfg_req_d = (state_d == S_CLKCFG);
        tg_en_d   = (state_d == S_RUN) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= S_IDLE;
            mem_res_q  <= '0;
            cfg_int_q  <= '0;
            cfg_frac_q <= '0;
            vld_q      <= 1'b0;
            stb_q      <= '0;
            tmo_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            cfg_req_q  <= 1'b0;
            tg_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_res_q  <= mem_res_d;
            cfg_int_q  <= cfg_int_d;
            cfg_frac_q <= cfg_frac_d;
            vld_q      <= vld_d;
            stb_q      <= stb_d;
            tmo_q      <= tmo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mem_req_q  <= mem_req_d;
            cfg_req_q  <= cfg_req_d;
            tg_en_q    <= tg_en_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign mem_res_o      = mem_res_q;
    assign mem_req_o      = mem_req_q;
    assign clk_cfg_int_o  = cfg_int_q;
    assign clk_cfg_frac_o = cfg_frac_q;
    assign clk_cfg_req_o  = cfg_req_q;
    assign tg_en_o        = tg_en_q;

endmodule
